// File: rtl/spi_arb_pkg.sv
// Shared types for the SPI master arbiter: FSM state encoding, requester
// identities and the contention pick.
package spi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      BUSY   = 2'd2,
      GAP    = 2'd3
   } state_t;

   localparam logic REQ_INERT = 1'b0;
   localparam logic REQ_A2D   = 1'b1;

   // Owner chosen in IDLE; rr is the requester favoured on contention.
   function automatic logic pick_owner(input logic r0, input logic r1,
                                       input logic rr, input bit prio_fix);
      logic w;
      if (r0 && r1) begin
         w = prio_fix ? REQ_INERT : rr;
      end else if (r1) begin
         w = REQ_A2D;
      end else begin
         w = REQ_INERT;
      end
      return w;
   endfunction

endpackage

// File: rtl/spi_arb.sv
// spi_arb: shares one SPI_mstr16 between the inertial sensor and the A2D reader,
// one 16-bit transaction per grant, with burst lock and an enforced idle gap.
module spi_arb
   import spi_arb_pkg::*;
#(
   parameter int unsigned GAP_CYC  = 4,
   parameter bit          PRIO_FIX = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        lock0,
   input  logic [15:0] cmd0,
   output logic        done0,
   input  logic        req1,
   input  logic        lock1,
   input  logic [15:0] cmd1,
   output logic        done1,
   output logic [15:0] rd_data,
   output logic        mstr_wrt,
   output logic [15:0] mstr_cmd,
   input  logic        mstr_done,
   input  logic [15:0] mstr_rd_data,
   input  logic        mstr_SS_n,
   output logic        SS0_n,
   output logic        SS1_n
);

   localparam logic [7:0] GAP_LOAD = 8'(GAP_CYC - 32'd1);

   state_t      state_r, state_s;
   logic        sel_r, sel_s;
   logic        rr_r, rr_s;
   logic        lock_r, lock_s;
   logic [7:0]  gap_r, gap_s;
   logic        req_sel_s;
   logic        xfer_done_s;
   logic [15:0] cmd_sel_s;

   assign req_sel_s   = (sel_r == REQ_A2D) ? req1 : req0;
   assign xfer_done_s = (state_r == BUSY) && mstr_done;
   assign cmd_sel_s   = (sel_s == REQ_A2D) ? cmd1 : cmd0;

   // Reset forces both selects high at once, before the master sees its own reset.
   assign SS0_n = (!rst && (sel_r == REQ_INERT)) ? mstr_SS_n : 1'b1;
   assign SS1_n = (!rst && (sel_r == REQ_A2D))   ? mstr_SS_n : 1'b1;

   // Next-state logic: grant, launch, wait for the master, then hold the gap.
   always_comb begin
      state_s = state_r;
      sel_s   = sel_r;
      rr_s    = rr_r;
      lock_s  = lock_r;
      gap_s   = gap_r;
      case (state_r)
         IDLE: begin
            if (req0 || req1) begin
               sel_s   = pick_owner(req0, req1, rr_r, PRIO_FIX);
               state_s = LAUNCH;
            end else begin
               state_s = IDLE;
            end
         end
         LAUNCH: begin
            state_s = BUSY;
         end
         BUSY: begin
            if (mstr_done) begin
               state_s = GAP;
               gap_s   = GAP_LOAD;
               lock_s  = (sel_r == REQ_A2D) ? lock1 : lock0;
            end else begin
               state_s = BUSY;
            end
         end
         GAP: begin
            if (gap_r != 8'd0) begin
               gap_s = gap_r - 8'd1;
            end else if (lock_r && req_sel_s) begin
               state_s = LAUNCH;
            end else begin
               state_s = IDLE;
               rr_s    = ~sel_r;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         sel_r   <= REQ_INERT;
         rr_r    <= REQ_INERT;
         lock_r  <= 1'b0;
         gap_r   <= 8'd0;
      end else begin
         state_r <= state_s;
         sel_r   <= sel_s;
         rr_r    <= rr_s;
         lock_r  <= lock_s;
         gap_r   <= gap_s;
      end
   end

   // Registered outputs toward the master and the requesters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstr_wrt <= 1'b0;
         mstr_cmd <= 16'h0000;
         rd_data  <= 16'h0000;
         done0    <= 1'b0;
         done1    <= 1'b0;
      end else begin
         mstr_wrt <= (state_s == LAUNCH);
         if (state_s == LAUNCH) begin
            mstr_cmd <= cmd_sel_s;
         end
         if (xfer_done_s) begin
            rd_data <= mstr_rd_data;
         end
         done0 <= xfer_done_s && (sel_r == REQ_INERT);
         done1 <= xfer_done_s && (sel_r == REQ_A2D);
      end
   end

endmodule
